lsu_arbiter: RTL
================

Name: lsu_arbiter

Overview:
- Shares the single word-wide LSU between two requesters: m0 is the core data port, m1 is a debug/DMA master.
- Sequences each access onto the LSU. Byte and halfword stores are done as read-modify-write (RMW), because the LSU port is word-only with no byte-enable.
- Extracts and sign- or zero-extends byte and halfword load data.
- Sits between the core/debug masters and lsu; the LSU memory map (DMEM, output and input peripheral regions) is unchanged.

Parameters:
- ADDR_W, 32, address width for requesters and LSU.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_m0_req  in  1  m0 request; held with all fields stable until o_m0_ack.
- i_m0_wren  in  1  1 = store, 0 = load.
- i_m0_addr  in  ADDR_W  byte address.
- i_m0_wdata  in  DATA_W  store data, right-aligned.
- i_m0_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- i_m0_uns  in  1  load zero-extend (1) or sign-extend (0).
- o_m0_ack  out  1  one-cycle completion pulse.
- o_m0_rdata  out  DATA_W  load result, valid while o_m0_ack is high; 0 otherwise.
- o_m0_err  out  1  misalignment error, valid with o_m0_ack.
- i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_size, i_m1_uns, o_m1_ack, o_m1_rdata, o_m1_err: identical to the m0 set, for m1.
- o_lsu_addr  out  ADDR_W  word address {addr[31:2],2'b00}.
- o_lsu_wren  out  1  LSU write enable.
- o_lsu_st_data  out  DATA_W  word to write.
- i_lsu_ld_data  in  DATA_W  LSU read word, valid the cycle after the address is presented.

Behaviour:
- Reset: FSM goes to IDLE and the round-robin pointer to m0. All outputs reset to 0: acks, err, rdata, o_lsu_wren, o_lsu_addr, o_lsu_st_data.
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE:
  - Samples both requests.
  - If only one is requesting, that one is granted.
  - If both are requesting, the pointer owner is granted and the pointer then moves to the other requester.
  - The granted request's fields are latched.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
  - IDLE goes straight to DONE, with no LSU activity.
  - ack=1, err=1, rdata=0.
- Load: IDLE -> RD -> WAIT -> DONE.
  - RD drives the address with wren=0.
  - WAIT captures i_lsu_ld_data.
  - DONE pulses ack and drives the extracted rdata.
  - Ack occurs 3 cycles after the grant edge.
- Word store: IDLE -> WR -> DONE.
  - WR drives wren=1, the address and wdata for exactly 1 cycle.
  - Ack occurs 2 cycles after the grant edge.
- Byte/half store: IDLE -> RD -> WAIT -> WR -> DONE.
  - The byte or half is merged into the captured word at lane addr[1:0] (half uses lane addr[1]).
  - Ack occurs 4 cycles after the grant edge.
- Extraction: the byte or half is selected by address lane. It is sign-extended unless uns=1.
- DONE always returns to IDLE, so there is at least 1 idle cycle between grants. A request still high in the cycle after its ack is a new request.
- o_lsu_wren is high only in WR and is never asserted for a load or a misaligned access.
- Reset mid-operation aborts the access: no ack, and wren is low after the reset edge. A partial RMW never writes.
- A requester dropping req before ack is a protocol violation. The behaviour is unspecified, but the FSM must still return to IDLE.

Optional Feature:
- Macro: LSU_ARBITER_LOCK_EN.
- With the macro: adds port i_m1_lock (in, 1).
  - If m1 is granted with lock=1, the next IDLE grants m1 whenever i_m1_req is high, ignoring round-robin.
  - This lets the debug master do atomic multi-access sequences.
  - Normal arbitration resumes on the first m1 grant with lock=0.
- Without the macro: the port does not exist and arbitration is pure round-robin.

Decomposition:
- Package lsu_arbiter_pkg holds:
  - state_e (IDLE, RD, WAIT, WR, DONE);
  - size_e (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10);
  - a request struct (wren, addr, wdata, size, uns);
  - region constants DMEM_BASE=32'h2000, OUT_BASE=32'h7000, IN_BASE=32'h7800.
- One sub-module, lsu_subword_unit: purely combinational lane merge for stores and extract/extend for loads. It is instantiated once.

Test Plan:
1. Store word: m0, addr 0x2004, data 0xDEADBEEF -> one-cycle wren with o_lsu_addr=0x2004 and st_data=0xDEADBEEF; ack 2 cycles after grant; err=0.
2. Store byte: m0, addr 0x2005, data 0x000000AA, after scenario 1 -> RD then WR of 0xDEADAAEF at 0x2004; ack 4 cycles after grant.
3. Load byte: addr 0x2005, uns=0 -> rdata 0xFFFFFFAA with ack; same with uns=1 -> 0x000000AA; half load at 0x2006 with uns=0 -> 0xFFFFDEAD.
4. Both requesters assert in the same cycle after reset -> m0 is served first, then m1. With both held continuously, grants alternate m0, m1, m0.
5. Misaligned: m1 half load at 0x2003 -> ack and err=1 one cycle after grant, rdata=0, o_lsu_wren never high.
6. Reset mid-operation: assert i_rst during WAIT of a byte store -> no ack, no wren, FSM in IDLE; the next word store to 0x7000 completes normally.

Source files
------------

// File: rtl/lsu_arbiter_pkg.sv
// lsu_arbiter_pkg: shared types, constants and helpers for the LSU arbiter.
//   state_e     : arbiter FSM states (also exported on the debug state port)
//   size_e      : access size encoding (2'b11 is treated as a word)
//   req_t       : latched request fields of the granted requester
//   *_BASE      : LSU memory map region bases (the arbiter does not remap them)
//   norm_size   : folds the 2'b11 size code onto SZ_WORD
//   is_misaligned: half on an odd address, or word not on a 4-byte boundary
package lsu_arbiter_pkg;

  localparam int unsigned LSU_ADDR_W = 32;
  localparam int unsigned LSU_DATA_W = 32;

  localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
  localparam logic [31:0] OUT_BASE  = 32'h0000_7000;
  localparam logic [31:0] IN_BASE   = 32'h0000_7800;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef struct packed {
    logic                  wren;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    logic [1:0]            size;
    logic                  uns;
  } req_t;

  function automatic size_e norm_size(input logic [1:0] size);
    case (size)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (norm_size(size))
      SZ_HALF: return lane[0];
      SZ_WORD: return (lane != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_arbiter_if.sv
// lsu_arbiter_if: bundle of the two requester ports and the word-wide LSU port.
//   i_mX_*  : request fields from requester X (0 = core data, 1 = debug/DMA)
//   o_mX_*  : completion (ack pulse, load data, misalignment error)
//   o_lsu_* : word address, write enable and store word towards the LSU
//   i_lsu_ld_data : LSU read word, valid the cycle after the address is shown
// Handshake: a requester raises i_mX_req with every field stable and keeps it
// so until the single-cycle o_mX_ack; o_mX_rdata/o_mX_err are meaningful only
// in that ack cycle. A req still high in the cycle after ack is a new request.
// Modports: master = requester/LSU environment side, slave = arbiter side.
interface lsu_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_m0_req;
  logic              i_m0_wren;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [DATA_W-1:0] i_m0_wdata;
  logic [1:0]        i_m0_size;
  logic              i_m0_uns;
  logic              o_m0_ack;
  logic [DATA_W-1:0] o_m0_rdata;
  logic              o_m0_err;

  logic              i_m1_req;
  logic              i_m1_wren;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [DATA_W-1:0] i_m1_wdata;
  logic [1:0]        i_m1_size;
  logic              i_m1_uns;
  logic              o_m1_ack;
  logic [DATA_W-1:0] o_m1_rdata;
  logic              o_m1_err;

  logic [ADDR_W-1:0] o_lsu_addr;
  logic              o_lsu_wren;
  logic [DATA_W-1:0] o_lsu_st_data;
  logic [DATA_W-1:0] i_lsu_ld_data;

  modport master (
    output i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_size, i_m0_uns,
    input  o_m0_ack, o_m0_rdata, o_m0_err,
    output i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_size, i_m1_uns,
    input  o_m1_ack, o_m1_rdata, o_m1_err,
    input  o_lsu_addr, o_lsu_wren, o_lsu_st_data,
    output i_lsu_ld_data
  );

  modport slave (
    input  i_m0_req, i_m0_wren, i_m0_addr, i_m0_wdata, i_m0_size, i_m0_uns,
    output o_m0_ack, o_m0_rdata, o_m0_err,
    input  i_m1_req, i_m1_wren, i_m1_addr, i_m1_wdata, i_m1_size, i_m1_uns,
    output o_m1_ack, o_m1_rdata, o_m1_err,
    output o_lsu_addr, o_lsu_wren, o_lsu_st_data,
    input  i_lsu_ld_data
  );
endinterface

// File: rtl/lsu_subword_unit.sv
// lsu_subword_unit: combinational byte/half lane handling around a word.
//   i_size, i_lane : access size and byte lane (addr[1:0])
//   i_uns          : zero-extend (1) or sign-extend (0) loads
//   i_wdata        : right-aligned store data
//   i_word         : word read from the LSU
//   o_merged       : i_word with the store lane(s) replaced (RMW write word)
//   o_rdata        : extracted and extended load result
module lsu_subword_unit
  import lsu_arbiter_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (i_lane)
      2'd0:    byte_sel = i_word[7:0];
      2'd1:    byte_sel = i_word[15:8];
      2'd2:    byte_sel = i_word[23:16];
      default: byte_sel = i_word[31:24];
    endcase
    // Halves live on lane 0 or lane 2; lane[0] is a misalignment and never gets here.
    half_sel = i_lane[1] ? i_word[31:16] : i_word[15:0];

    o_merged = i_word;
    o_rdata  = i_word;
    case (norm_size(i_size))
      SZ_BYTE: begin
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
        o_rdata = {{24{~i_uns & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
        o_rdata = {{16{~i_uns & half_sel[15]}}, half_sel};
      end
      default: begin
        o_merged = i_wdata;
        o_rdata  = i_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one word-only LSU between the core data port (m0) and a
// debug/DMA master (m1). Round-robin between simultaneous requests, byte/half
// stores done as read-modify-write, byte/half loads extracted and extended.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_m1_lock    : (LSU_ARBITER_LOCK_EN only) keep m1 granted for atomic runs
//   bus          : lsu_arbiter_if.slave, both requesters plus the LSU port
//   o_state      : debug view of the FSM state
// Optional feature macro: LSU_ARBITER_LOCK_EN.
// Sequences (edge numbers from the grant edge, ack is high in DONE):
//   load        IDLE -> RD -> WAIT -> DONE        ack sampled at edge 3
//   word store  IDLE -> WR -> DONE                ack sampled at edge 2
//   sub store   IDLE -> RD -> WAIT -> WR -> DONE  ack sampled at edge 4
//   misaligned  IDLE -> DONE                      ack sampled at edge 1
module lsu_arbiter
  import lsu_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic   i_clk,
  input  logic   i_rst,
`ifdef LSU_ARBITER_LOCK_EN
  input  logic   i_m1_lock,
`endif
  lsu_arbiter_if.slave bus,
  output state_e o_state
);

  state_e            state;
  req_t              req_q;
  logic              owner_q;   // 0 = m0, 1 = m1
  logic              rr_ptr;    // requester that wins the next tie
  logic              m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic [ADDR_W-1:0] lsu_addr_q;
  logic              lsu_wren_q;
  logic [DATA_W-1:0] lsu_st_data_q;

  req_t              m0_req, m1_req, gnt_req;
  logic              gnt_valid, gnt_m1, both_req, lock_hold;
  logic [ADDR_W-1:0] gnt_word_addr;
  logic [DATA_W-1:0] merged_word, load_result;

  assign m0_req = '{wren: bus.i_m0_wren, addr: bus.i_m0_addr, wdata: bus.i_m0_wdata,
                    size: bus.i_m0_size, uns: bus.i_m0_uns};
  assign m1_req = '{wren: bus.i_m1_wren, addr: bus.i_m1_addr, wdata: bus.i_m1_wdata,
                    size: bus.i_m1_size, uns: bus.i_m1_uns};

`ifdef LSU_ARBITER_LOCK_EN
  logic lock_q;
  // Lock follows the lock bit of the most recent m1 grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) lock_q <= 1'b0;
    else if (state == IDLE && gnt_valid && gnt_m1) lock_q <= i_m1_lock;
  end
  assign lock_hold = lock_q & bus.i_m1_req;
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    both_req  = bus.i_m0_req & bus.i_m1_req;
    gnt_valid = bus.i_m0_req | bus.i_m1_req;
    if (lock_hold)     gnt_m1 = 1'b1;
    else if (both_req) gnt_m1 = rr_ptr;
    else               gnt_m1 = bus.i_m1_req;
    gnt_req       = gnt_m1 ? m1_req : m0_req;
    gnt_word_addr = {gnt_req.addr[ADDR_W-1:2], 2'b00};
  end

  // Works on the latched request and the live LSU read word, so the WAIT
  // state can both merge (RMW) and extract (load) in the capturing cycle.
  lsu_subword_unit u_subword (
    .i_size   (req_q.size),
    .i_lane   (req_q.addr[1:0]),
    .i_uns    (req_q.uns),
    .i_wdata  (req_q.wdata),
    .i_word   (bus.i_lsu_ld_data),
    .o_merged (merged_word),
    .o_rdata  (load_result)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      req_q         <= '0;
      owner_q       <= 1'b0;
      rr_ptr        <= 1'b0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_err_q      <= 1'b0;
      m1_err_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      lsu_addr_q    <= '0;
      lsu_wren_q    <= 1'b0;
      lsu_st_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            req_q   <= gnt_req;
            owner_q <= gnt_m1;
            if (both_req && !lock_hold) rr_ptr <= ~gnt_m1;
            if (is_misaligned(gnt_req.size, gnt_req.addr[1:0])) begin
              // No LSU traffic at all: report the error straight away.
              state <= DONE;
              if (gnt_m1) begin m1_ack_q <= 1'b1; m1_err_q <= 1'b1; end
              else        begin m0_ack_q <= 1'b1; m0_err_q <= 1'b1; end
            end else if (gnt_req.wren && norm_size(gnt_req.size) == SZ_WORD) begin
              state         <= WR;
              lsu_wren_q    <= 1'b1;
              lsu_addr_q    <= gnt_word_addr;
              lsu_st_data_q <= gnt_req.wdata;
            end else begin
              state      <= RD;
              lsu_addr_q <= gnt_word_addr;
            end
          end
        end
        RD: begin
          state <= WAIT;
        end
        WAIT: begin
          if (req_q.wren) begin
            state         <= WR;
            lsu_wren_q    <= 1'b1;
            lsu_addr_q    <= {req_q.addr[ADDR_W-1:2], 2'b00};
            lsu_st_data_q <= merged_word;
          end else begin
            state <= DONE;
            if (owner_q) begin m1_ack_q <= 1'b1; m1_rdata_q <= load_result; end
            else         begin m0_ack_q <= 1'b1; m0_rdata_q <= load_result; end
          end
        end
        WR: begin
          state      <= DONE;
          lsu_wren_q <= 1'b0;
          if (owner_q) m1_ack_q <= 1'b1;
          else         m0_ack_q <= 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          m0_ack_q   <= 1'b0;
          m1_ack_q   <= 1'b0;
          m0_err_q   <= 1'b0;
          m1_err_q   <= 1'b0;
          m0_rdata_q <= '0;
          m1_rdata_q <= '0;
        end
        default: begin
          state      <= IDLE;
          lsu_wren_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_m0_ack      = m0_ack_q;
  assign bus.o_m0_err      = m0_err_q;
  assign bus.o_m0_rdata    = m0_rdata_q;
  assign bus.o_m1_ack      = m1_ack_q;
  assign bus.o_m1_err      = m1_err_q;
  assign bus.o_m1_rdata    = m1_rdata_q;
  assign bus.o_lsu_addr    = lsu_addr_q;
  assign bus.o_lsu_wren    = lsu_wren_q;
  assign bus.o_lsu_st_data = lsu_st_data_q;
  assign o_state           = state;

endmodule
